// File: rtl/key_debouncer.sv
// Push-button conditioner: per-key 2-flop synchronizer, stable-time debounce filter,
// press/release strobes and a shared press counter. Define KEY_DEBOUNCER_AUTOREPEAT_EN for auto-repeat.
module key_debouncer #(
  parameter int NUM_KEYS      = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_WIDTH     = 20
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_n,
  input  logic                count_clear,
  output logic [NUM_KEYS-1:0] level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [15:0]         press_count
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [NUM_KEYS-1:0]  sync1_q, sync2_q;
  logic [NUM_KEYS-1:0]  sync;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_KEYS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]  level_q, level_d;
  logic [NUM_KEYS-1:0]  press_q, press_d;
  logic [NUM_KEYS-1:0]  release_q, release_d;
  logic [15:0]          press_count_q, press_count_d;
  logic [15:0]          press_inc;

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

  logic [31:0]         rep_q [NUM_KEYS];
  logic [31:0]         rep_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] first_q, first_d;
`endif

  // Buttons are active-low; flip so 1 means pressed from here on.
  assign sync = ~sync2_q;

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync[k] == level_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == LAST_CNT) begin
        cnt_d[k]     = '0;
        level_d[k]   = ~level_q[k];
        press_d[k]   = ~level_q[k];
        release_d[k] = level_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    first_d = first_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      rep_d[k] = '0;
      if (press_d[k]) begin
        first_d[k] = 1'b1;
      end else if (level_q[k] && !release_d[k]) begin
        // Repeat timer counts edges since the last press strobe; a release edge suppresses it.
        if (rep_q[k] == (first_q[k] ? DELAY_LAST : PERIOD_LAST)) begin
          press_d[k] = 1'b1;
          first_d[k] = 1'b0;
        end else begin
          rep_d[k] = rep_q[k] + 32'd1;
        end
      end
    end
`endif
  end

  always_comb begin
    press_inc = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      press_inc = press_inc + 16'(press_d[k]);
    end
    press_count_d = count_clear ? 16'h0000 : press_count_q + press_inc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      level_q       <= '0;
      press_q       <= '0;
      release_q     <= '0;
      press_count_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q       <= keys_n;
      sync2_q       <= sync1_q;
      level_q       <= level_d;
      press_q       <= press_d;
      release_q     <= release_d;
      press_count_q <= press_count_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        rep_q[k] <= '0;
      end
    end else begin
      first_q <= first_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        rep_q[k] <= rep_d[k];
      end
    end
  end
`endif

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_count   = press_count_q;

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
Conditions the raw DE2 push-buttons before they reach the synth core and the display counter.
- Per key: 2-flop synchronizer and a stable-time debounce filter.
- Per key outputs: clean level, one-cycle press pulse, one-cycle release pulse.
- Shared outputs: 16-bit total-press counter, intended for the 7-segment decoders.
- Sits between KEY pins and the counter/tone logic; runs on the 50 MHz board clock.

Parameters:
- NUM_KEYS, 4, number of independent keys filtered.
- STABLE_CYCLES, 1000000, consecutive identical synchronized samples required to accept a change (20 ms at 50 MHz); legal range 2..2^CNT_WIDTH-1.
- CNT_WIDTH, 20, width of each per-key stability counter.

Ports:
- clock  input  1  board clock (CLOCK_50 at top level).
- reset  input  1  active-low asynchronous reset (driven from KEY[0] at top level).
- keys_n  input  NUM_KEYS  raw buttons, active-low (0 = pressed), asynchronous to clock.
- count_clear  input  1  synchronous clear of press_count.
- level  output  NUM_KEYS  debounced state, 1 = pressed.
- press_pulse  output  NUM_KEYS  one-cycle strobe on accepted press.
- release_pulse  output  NUM_KEYS  one-cycle strobe on accepted release.
- press_count  output  16  total accepted press pulses, all keys.

Behaviour:
- Reset:
  - Interface: one clock; reset is asynchronous and active-low.
  - While reset = 0: synchronizer flops = 1 (released); level = 0; press_pulse = 0; release_pulse = 0; stability counters = 0; press_count = 0.
  - Reset asserted mid-debounce discards the partial count; no pulse is emitted.
- Synchronizer: two flops per key; sync = inverted stage-2 output, so 1 = pressed.
- Per-key filter, one state bit (level) plus a counter:
  - Each edge with sync == level: counter <= 0.
  - Each edge with sync != level and counter < STABLE_CYCLES-1: counter increments.
  - Edge with sync != level and counter == STABLE_CYCLES-1:
    - level toggles and counter <= 0.
    - press_pulse (0→1) or release_pulse (1→0) is registered high for exactly that one cycle.
- Latency: raw input held steady from just before edge 1 → level and pulse change at edge STABLE_CYCLES+2.
- Glitch rejection: any bounce returning to level before acceptance resets the counter; no pulse, level unchanged.
- press_pulse and release_pulse are never high together for one key. Keys are fully independent.
- press_count:
  - Each edge: press_count <= press_count + popcount(press_pulse being asserted this edge).
  - Simultaneous presses on k keys add k in one cycle.
  - Wraps modulo 2^16 (FFFF + 1 = 0000).
  - count_clear = 1 forces 0 and wins over same-cycle pulses; those presses are not counted, but the pulses are still output.

Optional Feature:
- Macro: KEY_DEBOUNCER_AUTOREPEAT_EN.
- Defined: adds parameters REPEAT_DELAY (default 25000000) and REPEAT_PERIOD (default 5000000).
  - While level = 1, an extra press_pulse fires REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles.
  - Each repeat pulse is counted in press_count.
  - Release, or the repeat timer reaching the same cycle as a release acceptance, stops repeats; the release_pulse still fires and no repeat pulse occurs in that cycle.
- Not defined: exactly one press_pulse per accepted press; no repeat logic synthesized.

Test Plan:
All scenarios use STABLE_CYCLES = 8.
- Reset, then idle with keys_n = 4'hF → level = 0, all pulses 0, press_count = 0000 for 100 cycles.
- keys_n[1] driven low and held → level[1] = 1 and press_pulse[1] high for one cycle at edge 10; press_count = 0001. Later driven high and held → release_pulse[1] at edge 10 after the change; press_count unchanged.
- keys_n[2] bounces low 5 cycles / high 2 / low 6 / high → no pulse, level[2] stays 0. Then low 20 cycles → exactly one press_pulse[2].
- keys_n[0] and keys_n[3] pressed on the same edge → both pulses on the same cycle, press_count +2. count_clear asserted on that exact cycle instead → press_count = 0000, pulses still seen.
- press_count preset to FFFF by 65535 presses (or forced) plus one press → 0000. Reset asserted at counter = 5 mid-press → no pulse, level = 0 after release of reset.
- With KEY_DEBOUNCER_AUTOREPEAT_EN, REPEAT_DELAY = 20, REPEAT_PERIOD = 6, key 0 held 50 cycles after acceptance → pulses at +0, +20, +26, +32, +38, +44; press_count = 6.
